// File: rtl/mul_share_checker.sv
// Receiving-side checker for the masked multiplier.
// It decodes the operand shares and delays the expected product by the multiplier latency.
// It then compares that value against the decoded output shares and keeps run statistics.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; counters hold the last run's results
// S_RUN   | accepting vectors and comparing returned products
// S_DONE  | NCHECK comparisons completed without a halting mismatch
// S_FAIL  | halted on a mismatch (only when HALT_ON_ERR=1)
module mul_share_checker #(
  parameter int NSHARES     = 5,
  parameter int LAT         = 1,
  parameter int CNT_W       = 16,
  parameter int NCHECK      = 64,
  parameter int HALT_ON_ERR = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               clear,
  input  logic               in_valid,
  input  logic [NSHARES-1:0] x_sh,
  input  logic [NSHARES-1:0] y_sh,
  input  logic [NSHARES-1:0] z_sh,
  output logic               chk_valid,
  output logic               chk_pass,
  output logic               z_dec,
  output logic               exp_bit,
  output logic [CNT_W-1:0]   n_checks,
  output logic [CNT_W-1:0]   n_errors,
  output logic [CNT_W-1:0]   first_err,
  output logic               fail,
  output logic               done,
  output logic               busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_FAIL} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] NCHECK_C = CNT_W'(NCHECK);

  state_t           state, state_nxt;
  logic [LAT-1:0]   dly_v, dly_e;
  logic             stage_in_v, stage_in_e;
  logic             cmp, z_bit, match, mismatch, run_start;
  logic [CNT_W-1:0] checks_inc, errors_inc;

  assign run_start  = (state == S_IDLE) && start;
  assign stage_in_v = in_valid && (state == S_RUN);
  assign stage_in_e = (^x_sh) & (^y_sh);
  assign cmp        = dly_v[LAT-1] && (state == S_RUN);
  assign z_bit      = ^z_sh;
  assign match      = (z_bit == dly_e[LAT-1]);
  assign mismatch   = cmp && !match;
  // Saturating increments so a long run never wraps back to small values.
  assign checks_inc = (n_checks == CNT_MAX) ? n_checks : n_checks + 1'b1;
  assign errors_inc = (n_errors == CNT_MAX) ? n_errors : n_errors + 1'b1;

  assign done = (state == S_DONE) || (state == S_FAIL);
  assign busy = (state == S_RUN);

  // Next-state logic; a halting mismatch takes priority over reaching NCHECK.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      S_RUN: begin
        if (mismatch && (HALT_ON_ERR != 0))    state_nxt = S_FAIL;
        else if (cmp && checks_inc == NCHECK_C) state_nxt = S_DONE;
      end
      S_DONE, S_FAIL: if (clear) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Expected-product delay line; valid bits are flushed when a run starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dly_v <= '0;
      dly_e <= '0;
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        dly_v[i] <= dly_v[i-1];
        dly_e[i] <= dly_e[i-1];
      end
      dly_v[0] <= stage_in_v;
      dly_e[0] <= stage_in_e;
      if (run_start) dly_v <= '0;
    end
  end

  // Registered comparison result, one cycle after the compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_valid <= 1'b0;
      chk_pass  <= 1'b0;
      z_dec     <= 1'b0;
      exp_bit   <= 1'b0;
    end else begin
      chk_valid <= cmp;
      if (cmp) begin
        chk_pass <= match;
        z_dec    <= z_bit;
        exp_bit  <= dly_e[LAT-1];
      end
    end
  end

  // Run statistics; first_err records the check number of the first mismatch only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_checks  <= '0;
      n_errors  <= '0;
      first_err <= '0;
      fail      <= 1'b0;
    end else if (run_start) begin
      n_checks  <= '0;
      n_errors  <= '0;
      first_err <= '0;
      fail      <= 1'b0;
    end else if (cmp) begin
      n_checks <= checks_inc;
      if (mismatch) begin
        n_errors <= errors_inc;
        fail     <= 1'b1;
        if (!fail) first_err <= checks_inc;
      end
    end
  end

endmodule

// File: tb/tb_mul_share_checker.sv
// Directed bench for mul_share_checker.
// u_a: LAT=1 with halt-on-error; u_b: LAT=1 keep-counting; u_c: LAT=3 with halt-on-error.
// The operand inputs are shared by all three instances.
// Each latency gets its own product share stream, which is delayed by that latency.
module tb_mul_share_checker;
  localparam int N = 5;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst, start, clear, in_valid;
  logic [N-1:0] x_sh, y_sh, z1, z3;
  logic [N-1:0] zh1, zh2, zh3;

  logic a_cv, a_cp, a_zd, a_eb, a_fail, a_done, a_busy;
  logic b_cv, b_cp, b_zd, b_eb, b_fail, b_done, b_busy;
  logic c_cv, c_cp, c_zd, c_eb, c_fail, c_done, c_busy;
  logic [W-1:0] a_nc, a_ne, a_fe, b_nc, b_ne, b_fe, c_nc, c_ne, c_fe;

  int total = 0;
  int bad = 0;
  int pulses, passes;
  logic [11:0] pat;

  always #5 clk = ~clk;

  mul_share_checker #(.NSHARES(N), .LAT(1), .CNT_W(W), .NCHECK(64), .HALT_ON_ERR(1)) u_a (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .in_valid(in_valid),
    .x_sh(x_sh), .y_sh(y_sh), .z_sh(z1),
    .chk_valid(a_cv), .chk_pass(a_cp), .z_dec(a_zd), .exp_bit(a_eb),
    .n_checks(a_nc), .n_errors(a_ne), .first_err(a_fe),
    .fail(a_fail), .done(a_done), .busy(a_busy));

  mul_share_checker #(.NSHARES(N), .LAT(1), .CNT_W(W), .NCHECK(64), .HALT_ON_ERR(0)) u_b (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .in_valid(in_valid),
    .x_sh(x_sh), .y_sh(y_sh), .z_sh(z1),
    .chk_valid(b_cv), .chk_pass(b_cp), .z_dec(b_zd), .exp_bit(b_eb),
    .n_checks(b_nc), .n_errors(b_ne), .first_err(b_fe),
    .fail(b_fail), .done(b_done), .busy(b_busy));

  mul_share_checker #(.NSHARES(N), .LAT(3), .CNT_W(W), .NCHECK(64), .HALT_ON_ERR(1)) u_c (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .in_valid(in_valid),
    .x_sh(x_sh), .y_sh(y_sh), .z_sh(z3),
    .chk_valid(c_cv), .chk_pass(c_cp), .z_dec(c_zd), .exp_bit(c_eb),
    .n_checks(c_nc), .n_errors(c_ne), .first_err(c_fe),
    .fail(c_fail), .done(c_done), .busy(c_busy));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Random share encoding of bit b: XOR of all shares equals b.
  function automatic logic [N-1:0] enc(input logic b);
    logic [N-1:0] r;
    r = N'($urandom);
    r[N-1] = (^r[N-2:0]) ^ b;
    return r;
  endfunction

  // One clock slot: drive at the negedge, product shares follow LAT=1 and LAT=3 behind.
  task automatic slot(input logic v, input logic [N-1:0] xs, input logic [N-1:0] ys,
                      input logic [N-1:0] zs);
    in_valid = v;
    x_sh = xs;
    y_sh = ys;
    z1 = zh1;
    z3 = zh3;
    zh3 = zh2;
    zh2 = zh1;
    zh1 = zs;
    @(negedge clk);
    pulses += int'(a_cv);
    passes += int'(a_cv & a_cp);
  endtask

  task automatic idle();
    slot(1'b0, '0, '0, '0);
  endtask

  task automatic vec(input logic flip);
    logic xb, yb;
    xb = 1'($urandom);
    yb = 1'($urandom);
    slot(1'b1, enc(xb), enc(yb), enc((xb & yb) ^ flip));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    idle();
    start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    idle();
    clear = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    idle();
    rst = 1'b0;
    idle();
    pulses = 0;
    passes = 0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; clear = 1'b0; in_valid = 1'b0;
    x_sh = '0; y_sh = '0; z1 = '0; z3 = '0; zh1 = '0; zh2 = '0; zh3 = '0;
    pulses = 0; passes = 0;
    repeat (3) @(negedge clk);
    chk("rst_n_checks", 32'(a_nc), 0);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_done", 32'(a_done), 0);
    chk("rst_fail", 32'(a_fail), 0);
    chk("rst_chk_valid", 32'(a_cv), 0);
    chk("rst_first_err", 32'(a_fe), 0);
    rst = 1'b0;
    idle();

    // Reset mid-run after 10 checks, then restart from zero.
    pulse_start();
    chk("t1_busy", 32'(a_busy), 1);
    repeat (10) vec(1'b0);
    idle();
    chk("t1_pre_checks", 32'(a_nc), 10);
    rst = 1'b1;
    #1;
    chk("t1_rst_checks", 32'(a_nc), 0);
    chk("t1_rst_busy", 32'(a_busy), 0);
    chk("t1_rst_chk_valid", 32'(a_cv), 0);
    chk("t1_rst_chk_pass", 32'(a_cp), 0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    pulses = 0;
    passes = 0;
    pulse_start();
    chk("t1_restart_checks", 32'(a_nc), 0);
    chk("t1_restart_busy", 32'(a_busy), 1);

    // 64 correct back-to-back vectors.
    repeat (64) vec(1'b0);
    repeat (3) idle();
    chk("t2_pulses", 32'(pulses), 64);
    chk("t2_passes", 32'(passes), 64);
    chk("t2_done", 32'(a_done), 1);
    chk("t2_fail", 32'(a_fail), 0);
    chk("t2_errors", 32'(a_ne), 0);
    chk("t2_checks", 32'(a_nc), 64);
    chk("t2_busy", 32'(a_busy), 0);
    chk("t2_c_done", 32'(c_done), 1);
    chk("t2_c_checks", 32'(c_nc), 64);
    vec(1'b0);
    repeat (2) idle();
    chk("t2_after_done_checks", 32'(a_nc), 64);
    pulse_clear();
    chk("t2_clear_done", 32'(a_done), 0);
    chk("t2_clear_busy", 32'(a_busy), 0);
    chk("t2_clear_hold", 32'(a_nc), 64);

    // Fixed share vector.
    pulse_start();
    chk("t2_start_zero", 32'(a_nc), 0);
    slot(1'b1, 5'b10110, 5'b00111, 5'b00001);
    chk("t3_not_yet", 32'(a_cv), 0);
    idle();
    chk("t3_chk_valid", 32'(a_cv), 1);
    chk("t3_exp_bit", 32'(a_eb), 1);
    chk("t3_z_dec", 32'(a_zd), 1);
    chk("t3_chk_pass", 32'(a_cp), 1);
    chk("t3_checks", 32'(a_nc), 1);
    idle();
    chk("t3_pulse_len", 32'(a_cv), 0);

    // Halt on the 7th vector.
    do_reset();
    pulse_start();
    for (int i = 0; i < 10; i++) vec(i == 6);
    repeat (4) idle();
    chk("t4_pulses", 32'(pulses), 7);
    chk("t4_fail_pulses", 32'(pulses - passes), 1);
    chk("t4_fail", 32'(a_fail), 1);
    chk("t4_first_err", 32'(a_fe), 7);
    chk("t4_errors", 32'(a_ne), 1);
    chk("t4_checks", 32'(a_nc), 7);
    chk("t4_done", 32'(a_done), 1);
    chk("t4_busy", 32'(a_busy), 0);
    chk("t4_b_checks", 32'(b_nc), 10);
    chk("t4_b_first_err", 32'(b_fe), 7);
    chk("t4_b_busy", 32'(b_busy), 1);
    chk("t4_c_first_err", 32'(c_fe), 7);
    chk("t4_c_checks", 32'(c_nc), 7);

    // Keep counting with two corrupted vectors.
    do_reset();
    pulse_start();
    for (int i = 0; i < 64; i++) vec(i == 2 || i == 39);
    repeat (2) idle();
    chk("t5_b_errors", 32'(b_ne), 2);
    chk("t5_b_first_err", 32'(b_fe), 3);
    chk("t5_b_done", 32'(b_done), 1);
    chk("t5_b_fail", 32'(b_fail), 1);
    chk("t5_b_checks", 32'(b_nc), 64);
    chk("t5_b_busy", 32'(b_busy), 0);
    chk("t5_a_checks", 32'(a_nc), 3);
    chk("t5_a_first_err", 32'(a_fe), 3);

    // LAT=3 with gaps: check the chk_valid position slot by slot.
    do_reset();
    pulse_start();
    pat = 12'b0000_0001_1001;
    for (int k = 0; k < 12; k++) begin
      if (pat[k]) vec(1'b0);
      else        idle();
      chk($sformatf("t6_cv_%0d", k), 32'(c_cv), (k >= 3) ? 32'(pat[(k + 9) % 12]) : 0);
    end
    chk("t6_checks", 32'(c_nc), 3);
    chk("t6_errors", 32'(c_ne), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
